safe_obi_voter: RTL and testbench

// Parametrised OBI data-port voter between the NHARTS cores of the safe CPU wrapper and the bus system.
// Per transaction it collects requests from the active harts and compares them.
// A single voted request goes onto the bus; the response is broadcast back to the voted-in harts.

---
 rtl/safe_obi_voter.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_safe_obi_voter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/safe_obi_voter.sv
// -----------------------------------------------------------------------------
// safe_obi_voter
// OBI data-port voter sitting between the redundant harts of the safe CPU
// wrapper and the bus. Each transaction collects the requests of the harts
// that take part in the current mode, compares {we, be, addr, wdata} and
// either forwards one voted request to the bus or answers the harts with an
// error response. Disagreeing or late harts are flagged and counted.
//
// Ports
//   clk_i, rst_ni   clock, synchronous active-low reset
//   mode_i          0/3 = SINGLE (hart0), 1 = DMR (harts 0,1), 2 = TMR (0..2)
//   hart_req_i      per-hart OBI request
//   hart_resp_o     per-hart OBI response (gnt, rvalid, rdata)
//   bus_req_o       voted request toward the bus (registered)
//   bus_resp_i      bus response
//   clear_i         clears faulty_hart_o and err_cnt_o
//   mismatch_o      pulse in the cycle a compare failure is decided
//   timeout_o       pulse in the cycle the skew window expires
//   faulty_hart_o   sticky per-hart fault flags
//   err_cnt_o       saturating count of event cycles
//   intr_o          level interrupt, OR of the fault flags
// -----------------------------------------------------------------------------
package safe_obi_voter_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module safe_obi_voter
    import safe_obi_voter_pkg::*;
#(
    parameter int unsigned NHARTS    = 3,
    parameter int unsigned SKEW_MAX  = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [1:0]              mode_i,
    input  obi_req_t  [NHARTS-1:0]  hart_req_i,
    output obi_resp_t [NHARTS-1:0]  hart_resp_o,
    output obi_req_t                bus_req_o,
    input  obi_resp_t               bus_resp_i,
    input  logic                    clear_i,
    output logic                    mismatch_o,
    output logic                    timeout_o,
    output logic [NHARTS-1:0]       faulty_hart_o,
    output logic [ERR_CNT_W-1:0]    err_cnt_o,
    output logic                    intr_o
);
    if (NHARTS < 3) begin : g_nharts_check
        $error("safe_obi_voter: NHARTS must be at least 3");
    end
    if (SKEW_MAX < 1 || SKEW_MAX > 255) begin : g_skew_check
        $error("safe_obi_voter: SKEW_MAX must be within 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_ISSUE, S_WAIT_R, S_ERR_GNT, S_ERR_RESP
    } state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } fields_t;

    state_t               state_reg, state_next;
    logic [1:0]           mode_reg, mode_next;
    logic [7:0]           skew_reg, skew_next;
    logic [2:0]           served_reg, served_next;
    fields_t              voted_reg, voted_next;
    logic [NHARTS-1:0]    faulty_reg, faulty_next;
    logic [ERR_CNT_W-1:0] err_cnt_reg, err_cnt_next;

    fields_t           f [3];
    logic [2:0]        req_vec;
    logic [1:0]        eval_mode;
    logic [2:0]        active_mask, present;
    logic              eq01, eq02, eq12, pair_agree;
    logic              full_eval, skew_expired;
    logic              mismatch, timeout, event_hit;
    logic [2:0]        flag_set;
    logic [NHARTS-1:0] flag_ext;

    // Only harts 0..2 ever take part in a vote.
    for (genvar gi = 0; gi < 3; gi++) begin : g_fields
        assign f[gi]       = '{we: hart_req_i[gi].we, be: hart_req_i[gi].be,
                               addr: hart_req_i[gi].addr, wdata: hart_req_i[gi].wdata};
        assign req_vec[gi] = hart_req_i[gi].req;
    end

    // While idle the new transaction's mode is still on mode_i; once a
    // transaction has started, the latched copy rules.
    assign eval_mode = (state_reg == S_IDLE) ? mode_i : mode_reg;

    always_comb begin
        case (eval_mode)
            2'd1:    active_mask = 3'b011;
            2'd2:    active_mask = 3'b111;
            default: active_mask = 3'b001;
        endcase
    end

    assign present    = active_mask & req_vec;
    assign eq01       = (f[0] == f[1]);
    assign eq02       = (f[0] == f[2]);
    assign eq12       = (f[1] == f[2]);
    assign pair_agree = (present == 3'b011 && eq01) || (present == 3'b101 && eq02) ||
                        (present == 3'b110 && eq12);

    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        skew_next    = skew_reg;
        served_next  = served_reg;
        voted_next   = voted_reg;
        full_eval    = 1'b0;
        skew_expired = 1'b0;
        mismatch     = 1'b0;
        timeout      = 1'b0;
        flag_set     = 3'b000;

        case (state_reg)
            S_IDLE: begin
                if (|present) begin
                    mode_next  = mode_i;
                    skew_next  = '0;
                    state_next = S_COLLECT;
                    full_eval  = (present == active_mask);
                end
            end
            S_COLLECT: begin
                // skew_reg counts finished COLLECT cycles, so this cycle lies
                // skew_reg+1 cycles after the first request; a hart arriving
                // exactly SKEW_MAX cycles late is still accepted.
                if (present == active_mask) begin
                    full_eval = 1'b1;
                end else if (32'(skew_reg) + 32'd1 >= SKEW_MAX) begin
                    skew_expired = 1'b1;
                end else begin
                    skew_next = skew_reg + 8'd1;
                end
            end
            S_ISSUE:    if (bus_resp_i.gnt)    state_next = S_WAIT_R;
            S_WAIT_R:   if (bus_resp_i.rvalid) state_next = S_IDLE;
            S_ERR_GNT:  state_next = S_ERR_RESP;
            S_ERR_RESP: state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase

        if (full_eval) begin
            case (eval_mode)
                2'd1: begin
                    served_next = 3'b011;
                    if (eq01) begin
                        state_next = S_ISSUE;
                        voted_next = f[0];
                    end else begin
                        mismatch   = 1'b1;
                        flag_set   = 3'b011;
                        state_next = S_ERR_GNT;
                    end
                end
                2'd2: begin
                    state_next = S_ISSUE;
                    if (eq01 && eq02) begin
                        served_next = 3'b111;
                        voted_next  = f[0];
                    end else if (eq01) begin
                        served_next = 3'b011;
                        voted_next  = f[0];
                        flag_set    = 3'b100;
                        mismatch    = 1'b1;
                    end else if (eq02) begin
                        served_next = 3'b101;
                        voted_next  = f[0];
                        flag_set    = 3'b010;
                        mismatch    = 1'b1;
                    end else if (eq12) begin
                        served_next = 3'b110;
                        voted_next  = f[1];
                        flag_set    = 3'b001;
                        mismatch    = 1'b1;
                    end else begin
                        served_next = 3'b111;
                        flag_set    = 3'b111;
                        mismatch    = 1'b1;
                        state_next  = S_ERR_GNT;
                    end
                end
                default: begin
                    state_next  = S_ISSUE;
                    served_next = 3'b001;
                    voted_next  = f[0];
                end
            endcase
        end else if (skew_expired) begin
            timeout     = 1'b1;
            flag_set    = active_mask & ~present;
            served_next = present;
            if (eval_mode == 2'd2 && pair_agree) begin
                state_next = S_ISSUE;
                voted_next = present[0] ? f[0] : f[1];
            end else begin
                state_next = S_ERR_GNT;
            end
        end
    end

    for (genvar gi = 0; gi < NHARTS; gi++) begin : g_flag_ext
        if (gi < 3) begin : g_vote
            assign flag_ext[gi] = flag_set[gi];
        end else begin : g_novote
            assign flag_ext[gi] = 1'b0;
        end
    end

    // A clear coinciding with an event keeps only what this cycle found.
    assign event_hit = mismatch | timeout;

    always_comb begin
        faulty_next  = faulty_reg | flag_ext;
        err_cnt_next = err_cnt_reg;
        if (clear_i) begin
            faulty_next  = flag_ext;
            err_cnt_next = event_hit ? ERR_CNT_W'(1) : '0;
        end else if (event_hit && err_cnt_reg != {ERR_CNT_W{1'b1}}) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= S_IDLE;
            mode_reg    <= 2'd0;
            skew_reg    <= '0;
            served_reg  <= '0;
            voted_reg   <= '0;
            faulty_reg  <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            skew_reg    <= skew_next;
            served_reg  <= served_next;
            voted_reg   <= voted_next;
            faulty_reg  <= faulty_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    // The request is held exactly while ISSUE waits for the bus grant.
    assign bus_req_o.req   = (state_reg == S_ISSUE);
    assign bus_req_o.we    = voted_reg.we;
    assign bus_req_o.be    = voted_reg.be;
    assign bus_req_o.addr  = voted_reg.addr;
    assign bus_req_o.wdata = voted_reg.wdata;

    for (genvar gi = 0; gi < NHARTS; gi++) begin : g_resp
        if (gi < 3) begin : g_vote
            logic rv_bus;
            assign rv_bus = served_reg[gi] && state_reg == S_WAIT_R && bus_resp_i.rvalid;
            assign hart_resp_o[gi].gnt    = served_reg[gi] &&
                                            ((state_reg == S_ISSUE && bus_resp_i.gnt) ||
                                             state_reg == S_ERR_GNT);
            assign hart_resp_o[gi].rvalid = rv_bus || (served_reg[gi] && state_reg == S_ERR_RESP);
            assign hart_resp_o[gi].rdata  = rv_bus ? bus_resp_i.rdata : '0;
        end else begin : g_novote
            assign hart_resp_o[gi] = '0;
        end
    end

    assign mismatch_o    = mismatch;
    assign timeout_o     = timeout;
    assign faulty_hart_o = faulty_reg;
    assign err_cnt_o     = err_cnt_reg;
    assign intr_o        = |faulty_reg;
endmodule

// File: tb/tb_safe_obi_voter.sv
// Bench for safe_obi_voter: directed scenarios followed by random
// transactions, all checked against a per-transaction outcome model.
module tb_safe_obi_voter;
    import safe_obi_voter_pkg::*;

    localparam int NH = 3;
    localparam int SK = 4;
    localparam int EW = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           mode;
    obi_req_t  [NH-1:0]   hart_req;
    obi_resp_t [NH-1:0]   hart_resp;
    obi_req_t             bus_req;
    obi_resp_t            bus_resp;
    logic                 clear;
    logic                 mismatch, timeout, intr;
    logic [NH-1:0]        faulty;
    logic [EW-1:0]        err_cnt;

    int        n_cmp = 0;
    int        n_bad = 0;
    int        n_txn = 0;
    logic [2:0] exp_faulty = '0;
    int        exp_cnt = 0;

    safe_obi_voter #(.NHARTS(NH), .SKEW_MAX(SK), .ERR_CNT_W(EW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode),
        .hart_req_i(hart_req), .hart_resp_o(hart_resp),
        .bus_req_o(bus_req), .bus_resp_i(bus_resp), .clear_i(clear),
        .mismatch_o(mismatch), .timeout_o(timeout), .faulty_hart_o(faulty),
        .err_cnt_o(err_cnt), .intr_o(intr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        rst_n    = 1'b1;
        clear    = 1'b0;
        hart_req = '0;
        bus_resp = '0;
    endtask

    // a0..a2: cycle each hart raises req (-1 = never); gd/rd: bus gnt/rvalid
    // delays; clr_at: cycle with clear_i high; rst_at: cycle with reset low.
    task automatic run_txn(input logic [1:0] m, input int a0, input int a1, input int a2,
                           input logic [68:0] f0, input logic [68:0] f1, input logic [68:0] f2,
                           input int gd, input int rd, input logic [31:0] rdat,
                           input int clr_at, input int rst_at);
        int          arr[3];
        logic [68:0] fl[3];
        logic [2:0]  act, pres, served, flags, fl_now;
        int          n_act, first, last, t_dec, g, gc, rv_hart, bus_rv, end_cyc, hold_end;
        int          best_v, win, votes;
        bit          all_in, timed, issue, ev_mism, ev_now;
        logic        exp_g, exp_rv;
        arr[0] = a0; arr[1] = a1; arr[2] = a2;
        fl[0] = f0;  fl[1] = f1;  fl[2] = f2;

        act = (m == 2'd1) ? 3'b011 : (m == 2'd2) ? 3'b111 : 3'b001;
        n_act = 0; first = 1000; last = -1; all_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (act[i]) begin
                n_act++;
                if (arr[i] >= 0) begin
                    if (arr[i] < first) first = arr[i];
                    if (arr[i] > last)  last  = arr[i];
                end else begin
                    all_in = 1'b0;
                end
            end
        end
        if (all_in && last - first <= SK) begin
            timed = 1'b0; t_dec = last; pres = act;
        end else begin
            timed = 1'b1; t_dec = first + SK; pres = '0;
            for (int i = 0; i < 3; i++)
                if (act[i] && arr[i] >= 0 && arr[i] <= t_dec) pres[i] = 1'b1;
        end
        best_v = 0; win = 0;
        for (int i = 0; i < 3; i++) begin
            if (pres[i]) begin
                votes = 0;
                for (int j = 0; j < 3; j++)
                    if (pres[j] && fl[j] == fl[i]) votes++;
                if (votes > best_v) begin best_v = votes; win = i; end
            end
        end
        served = '0; flags = '0; ev_mism = 1'b0; issue = 1'b0;
        if (!timed) begin
            if (best_v == n_act) begin
                issue = 1'b1; served = pres;
            end else if (m == 2'd2 && best_v == 2) begin
                issue = 1'b1;
                for (int j = 0; j < 3; j++)
                    if (pres[j] && fl[j] == fl[win]) served[j] = 1'b1;
                flags = pres & ~served; ev_mism = 1'b1;
            end else begin
                served = pres; flags = pres; ev_mism = 1'b1;
            end
        end else begin
            flags  = act & ~pres;
            served = pres;
            issue  = (m == 2'd2 && $countones(pres) == 2 && best_v == 2);
        end

        if (issue) begin
            g = t_dec + 1 + gd; gc = g; rv_hart = g + 1 + rd; bus_rv = rv_hart;
        end else begin
            g = -1; gc = t_dec + 1; rv_hart = t_dec + 2; bus_rv = -1;
        end
        end_cyc = rv_hart;
        if (rst_at >= 0) begin end_cyc = rst_at + 1; bus_rv = rst_at + 1; rv_hart = -1; end
        hold_end = (rst_at >= 0) ? rst_at : end_cyc;

        for (int k = 0; k <= end_cyc; k++) begin
            @(posedge clk); #1;
            rst_n = (k != rst_at);
            clear = (k == clr_at);
            mode  = (k <= first) ? m : 2'($urandom_range(0, 3));
            for (int i = 0; i < 3; i++)
                hart_req[i] = {(arr[i] >= 0 && k >= arr[i] && k <= hold_end), fl[i]};
            bus_resp.gnt    = (k == g);
            bus_resp.rvalid = (k == bus_rv);
            bus_resp.rdata  = (k == bus_rv) ? rdat : $urandom;
            @(negedge clk);
            check_val($sformatf("mismatch t%0d k%0d", n_txn, k), mismatch, (k == t_dec) && ev_mism);
            check_val($sformatf("timeout t%0d k%0d", n_txn, k), timeout, (k == t_dec) && timed);
            check_val($sformatf("bus_req t%0d k%0d", n_txn, k), bus_req.req, issue && k > t_dec && k <= g);
            if (issue && k > t_dec && k <= g)
                check_val($sformatf("bus_fields t%0d k%0d", n_txn, k),
                          {bus_req.we, bus_req.be, bus_req.addr, bus_req.wdata}, fl[win]);
            for (int i = 0; i < 3; i++) begin
                exp_g  = served[i] && (k == gc) && (rst_at < 0 || k < rst_at);
                exp_rv = served[i] && (k == rv_hart);
                check_val($sformatf("gnt%0d t%0d k%0d", i, n_txn, k), hart_resp[i].gnt, exp_g);
                check_val($sformatf("rvalid%0d t%0d k%0d", i, n_txn, k), hart_resp[i].rvalid, exp_rv);
                if (exp_rv)
                    check_val($sformatf("rdata%0d t%0d k%0d", i, n_txn, k), hart_resp[i].rdata,
                              issue ? rdat : 32'd0);
            end
            check_val($sformatf("faulty t%0d k%0d", n_txn, k), faulty, exp_faulty);
            check_val($sformatf("err_cnt t%0d k%0d", n_txn, k), err_cnt, exp_cnt);
            check_val($sformatf("intr t%0d k%0d", n_txn, k), intr, |exp_faulty);

            if (k == rst_at) begin
                exp_faulty = '0; exp_cnt = 0;
            end else begin
                fl_now = (k == t_dec) ? flags : 3'b000;
                ev_now = (k == t_dec) && (ev_mism || timed);
                if (k == clr_at) begin
                    exp_faulty = fl_now;
                    exp_cnt    = ev_now ? 1 : 0;
                end else begin
                    exp_faulty = exp_faulty | fl_now;
                    if (ev_now && exp_cnt < (1 << EW) - 1) exp_cnt++;
                end
            end
        end
        $display("txn %0d mode=%0d dec=%0d issue=%0d served=%b flags=%b err_cnt=%0d",
                 n_txn, m, t_dec, issue, served, flags, exp_cnt);
        n_txn++;
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #1;
    endtask

    localparam logic [68:0] F_OK  = {1'b1, 4'hF, 32'h1000_0040, 32'hDEADBEEF};
    localparam logic [68:0] F_BAD = {1'b1, 4'hF, 32'h1000_0040, 32'hDEADBEEE};
    localparam logic [68:0] F_A0  = {1'b0, 4'hF, 32'h0000_0000, 32'h0};
    localparam logic [68:0] F_A4  = {1'b0, 4'hF, 32'h0000_0004, 32'h0};

    initial begin
        logic [1:0]  m;
        int          a[3];
        logic [68:0] base, fr[3];
        drive_idle();
        mode  = 2'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst bus_req", bus_req, '0);
        check_val("rst hart_resp", hart_resp, '0);
        check_val("rst faulty", faulty, '0);
        check_val("rst err_cnt", err_cnt, '0);
        check_val("rst intr", intr, 1'b0);
        check_val("rst pulses", {mismatch, timeout}, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // TMR agreement, TMR single dissenter, DMR disagreement, TMR timeout.
        run_txn(2'd2, 0, 0, 0, F_OK, F_OK, F_OK, 0, 0, 32'hCAFE_0001, -1, -1);
        run_txn(2'd2, 0, 0, 0, F_OK, F_OK, F_BAD, 1, 2, 32'hCAFE_0002, -1, -1);
        run_txn(2'd1, 0, 0, -1, F_A0, F_A4, F_A0, 0, 0, 32'hCAFE_0003, -1, -1);
        run_txn(2'd2, 0, -1, 0, F_OK, F_OK, F_OK, 0, 1, 32'hCAFE_0004, -1, -1);
        // Counter saturation, then clear together with an event.
        run_txn(2'd1, 0, 0, -1, F_A0, F_A4, F_A0, 0, 0, 32'h0, -1, -1);
        run_txn(2'd1, 1, 0, -1, F_A0, F_A4, F_A0, 0, 0, 32'h0, -1, -1);
        run_txn(2'd1, 0, 0, -1, F_A0, F_A4, F_A0, 0, 0, 32'h0, 0, -1);
        // Skew boundary: last hart exactly SK cycles late, then SK+1 late.
        run_txn(2'd1, 0, SK, -1, F_A0, F_A0, F_A0, 0, 0, 32'h1234, -1, -1);
        run_txn(2'd1, 0, SK + 1, -1, F_A0, F_A0, F_A0, 0, 0, 32'h1234, -1, -1);
        // Reset while waiting for rvalid; the late rvalid must be ignored.
        run_txn(2'd2, 0, 0, 0, F_OK, F_OK, F_OK, 0, 3, 32'hBAD0_0BAD, -1, 2);

        for (int t = 0; t < 150; t++) begin
            m    = 2'($urandom_range(0, 3));
            base = {5'($urandom), $urandom, $urandom};
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 4) == 0)      a[i] = -1;
                else if ($urandom_range(0, 3) != 0) a[i] = $urandom_range(0, 2);
                else                                a[i] = $urandom_range(0, SK + 2);
                fr[i] = ($urandom_range(0, 3) == 0) ? (base ^ (69'd1 << $urandom_range(0, 68))) : base;
            end
            if (a[0] < 0) a[0] = $urandom_range(0, 2);
            run_txn(m, a[0], a[1], a[2], fr[0], fr[1], fr[2],
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom,
                    ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
